// File: rtl/apb_master_mq.sv
// ---------------------------------------------------------------------------
// apb_master_mq
//   APB master with a command FIFO in front and a single-entry response
//   holding register behind. Commands are queued, then issued one at a time
//   as SETUP -> ACCESS transfers to one of NUM_SLAVES slaves. The slave is
//   picked by the top SIDX_W address bits. ACCESS waits are bounded by
//   TIMEOUT cycles.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command push handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_strb   command payload
//   cmd_count             FIFO occupancy
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_error,
//   rsp_timeout           response payload
//   PADDR, PSEL, PENABLE,
//   PWRITE, PWDATA, PSTRB APB request outputs (PSEL one-hot)
//   PRDATA, PREADY,
//   PSLVERR               per-slave APB return inputs
// ---------------------------------------------------------------------------
module apb_master_mq #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_error,
  output logic                             rsp_timeout,
  output logic [$clog2(CMD_DEPTH):0]       cmd_count,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SIDX_W = $clog2(NUM_SLAVES);
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Command FIFO storage (payload only; occupancy lives in the control regs)
  logic                  fifo_write_q [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [CMD_DEPTH];
  logic [STRB_W-1:0]     fifo_strb_q  [CMD_DEPTH];

  // Control / output registers
  state_e                state_q,       state_d;
  logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0]      count_q,       count_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic [WAIT_W-1:0]     wait_cnt_q,    wait_cnt_d;
  logic [SIDX_W-1:0]     sidx_q,        sidx_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [NUM_SLAVES-1:0] psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic [STRB_W-1:0]     pstrb_q,       pstrb_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_error_q,   rsp_error_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic                  push;
  logic                  pop;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [STRB_W-1:0]     head_strb;
  logic [SIDX_W-1:0]     head_sidx;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign head_write = fifo_write_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];
  assign head_strb  = fifo_strb_q[rd_ptr_q];
  assign head_sidx  = head_addr[ADDR_WIDTH-1 -: SIDX_W];

  // cmd_ready is registered, so a full FIFO refuses a push even when the
  // FSM pops in the same cycle.
  assign push = cmd_valid && cmd_ready_q;
  // A new transfer starts only if the response slot is free by this edge.
  assign pop  = (state_q == ST_IDLE) && (count_q != '0) &&
                (!rsp_valid_q || rsp_ready);

  // Only the selected slave's return signals are looked at.
  assign sel_ready = PREADY[sidx_q];
  assign sel_err   = PSLVERR[sidx_q];

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sidx_q == SIDX_W'(i)) sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
      fifo_strb_q[wr_ptr_q]  <= cmd_strb;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wait_cnt_d    = wait_cnt_q;
    sidx_d        = sidx_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    cmd_ready_d = (count_d < CNT_W'(CMD_DEPTH));

    // Consumed response drops; a completion below may reload it.
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d    = ST_SETUP;
          wait_cnt_d = '0;
          sidx_d     = head_sidx;
          paddr_d    = head_addr;
          psel_d     = '0;
          psel_d[head_sidx] = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = head_write;
          pwdata_d   = head_write ? head_wdata : '0;
          pstrb_d    = head_write ? head_strb  : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d       = ST_IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : sel_rdata;
          rsp_error_d   = sel_err;
          rsp_timeout_d = 1'b0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without PREADY: give up now.
          state_d       = ST_IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_ready_q   <= 1'b0;
      wait_cnt_q    <= '0;
      sidx_q        <= '0;
      paddr_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cmd_ready_q   <= cmd_ready_d;
      wait_cnt_q    <= wait_cnt_d;
      sidx_q        <= sidx_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign cmd_count   = count_q;
  assign PADDR       = paddr_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_mq.sv
// ---------------------------------------------------------------------------
// tb_apb_master_mq
//   Directed bench for apb_master_mq at default parameters. The bench drives
//   the slave return signals itself and checks every APB phase and response
//   against hand-computed values.
// ---------------------------------------------------------------------------
module tb_apb_master_mq;

  logic         PCLK;
  logic         PRESET;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [15:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic [3:0]   cmd_strb;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_error;
  logic         rsp_timeout;
  logic [2:0]   cmd_count;
  logic [15:0]  PADDR;
  logic [3:0]   PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;
  logic [3:0]   PSLVERR;

  int n_chk  = 0;
  int n_fail = 0;

  apb_master_mq #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_SLAVES(4), .CMD_DEPTH(4), .TIMEOUT(15)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .cmd_count(cmd_count),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Counts ACCESS cycles; raises the masked PREADY bits in cycle raise_at.
  task automatic count_access(input logic [3:0] rdy_mask, input int raise_at,
                              output int n);
    n = 0;
    while (PENABLE === 1'b1 && n < 40) begin
      n++;
      if (n == raise_at) PREADY = PREADY | rdy_mask;
      tick();
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    chk_eq("rsp_cleared", rsp_valid, 1'b0);
    rsp_ready = 1'b0;
  endtask

  int n;
  int got;
  int cyc;
  logic [15:0] bp_addr [5];
  logic [31:0] bp_exp  [5];

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = '0;
    PSLVERR   = '0;

    // Reset state
    tick();
    tick();
    chk_eq("rst_cmd_ready", cmd_ready, 1'b0);
    chk_eq("rst_psel",      PSEL, 4'b0000);
    chk_eq("rst_penable",   PENABLE, 1'b0);
    chk_eq("rst_rsp_valid", rsp_valid, 1'b0);
    chk_eq("rst_cmd_count", cmd_count, 3'd0);
    chk_eq("rst_paddr",     PADDR, 16'h0000);
    PRESET = 1'b0;
    tick();
    chk_eq("rel_cmd_ready", cmd_ready, 1'b1);

    // Write, zero wait states, slave 1
    PREADY = 4'b0010;
    PRDATA[1*32 +: 32] = 32'h11111111;
    push_cmd(1'b1, 16'h4010, 32'hDEADBEEF, 4'hF);            // E0
    chk_eq("wr_e0_count", cmd_count, 3'd1);
    chk_eq("wr_e0_psel",  PSEL, 4'b0000);
    tick();                                                   // E1
    chk_eq("wr_setup_psel",    PSEL, 4'b0010);
    chk_eq("wr_setup_penable", PENABLE, 1'b0);
    chk_eq("wr_setup_paddr",   PADDR, 16'h4010);
    chk_eq("wr_setup_pwrite",  PWRITE, 1'b1);
    chk_eq("wr_setup_pwdata",  PWDATA, 32'hDEADBEEF);
    chk_eq("wr_setup_pstrb",   PSTRB, 4'hF);
    chk_eq("wr_setup_count",   cmd_count, 3'd0);
    chk_eq("wr_setup_rspv",    rsp_valid, 1'b0);
    tick();                                                   // E2
    chk_eq("wr_access_penable", PENABLE, 1'b1);
    chk_eq("wr_access_psel",    PSEL, 4'b0010);
    chk_eq("wr_access_paddr",   PADDR, 16'h4010);
    chk_eq("wr_access_pwdata",  PWDATA, 32'hDEADBEEF);
    tick();                                                   // E3
    chk_eq("wr_rsp_valid",   rsp_valid, 1'b1);
    chk_eq("wr_rsp_error",   rsp_error, 1'b0);
    chk_eq("wr_rsp_timeout", rsp_timeout, 1'b0);
    chk_eq("wr_rsp_rdata",   rsp_rdata, 32'h0);
    chk_eq("wr_done_psel",   PSEL, 4'b0000);
    chk_eq("wr_done_penable", PENABLE, 1'b0);
    chk_eq("wr_idle_paddr",  PADDR, 16'h4010);
    chk_eq("wr_idle_pwdata", PWDATA, 32'hDEADBEEF);
    consume();

    // Read with three wait states on slave 3; slave 0 is ready/erroring but unselected
    PREADY  = 4'b0001;
    PSLVERR = 4'b0001;
    PRDATA[3*32 +: 32] = 32'h12345678;
    PRDATA[0*32 +: 32] = 32'hFFFF0000;
    push_cmd(1'b0, 16'hC004, 32'h55555555, 4'hA);
    tick();
    chk_eq("rd_setup_psel",   PSEL, 4'b1000);
    chk_eq("rd_setup_pwrite", PWRITE, 1'b0);
    chk_eq("rd_setup_pwdata", PWDATA, 32'h0);
    chk_eq("rd_setup_pstrb",  PSTRB, 4'h0);
    chk_eq("rd_setup_paddr",  PADDR, 16'hC004);
    tick();
    count_access(4'b1000, 4, n);
    chk_eq("rd_access_cycles", n, 4);
    chk_eq("rd_rsp_valid",   rsp_valid, 1'b1);
    chk_eq("rd_rsp_rdata",   rsp_rdata, 32'h12345678);
    chk_eq("rd_rsp_error",   rsp_error, 1'b0);
    chk_eq("rd_rsp_timeout", rsp_timeout, 1'b0);
    tick();
    chk_eq("rd_hold_valid", rsp_valid, 1'b1);
    chk_eq("rd_hold_rdata", rsp_rdata, 32'h12345678);
    chk_eq("rd_idle_paddr", PADDR, 16'hC004);
    consume();
    PREADY  = 4'b0000;
    PSLVERR = 4'b0000;

    // Timeout: slave 2 never ready
    PRDATA[2*32 +: 32] = 32'hAAAA5555;
    push_cmd(1'b0, 16'h8000, 32'h0, 4'h0);
    tick();
    chk_eq("to_setup_psel", PSEL, 4'b0100);
    tick();
    count_access(4'b0000, 0, n);
    chk_eq("to_access_cycles", n, 15);
    chk_eq("to_rsp_valid",   rsp_valid, 1'b1);
    chk_eq("to_rsp_error",   rsp_error, 1'b1);
    chk_eq("to_rsp_timeout", rsp_timeout, 1'b1);
    chk_eq("to_rsp_rdata",   rsp_rdata, 32'h0);
    chk_eq("to_psel",        PSEL, 4'b0000);
    chk_eq("to_penable",     PENABLE, 1'b0);
    consume();

    // PREADY in the 15th ACCESS cycle is a normal completion
    PRDATA[0*32 +: 32] = 32'hCAFEF00D;
    push_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    tick();
    tick();
    count_access(4'b0001, 15, n);
    chk_eq("edge_access_cycles", n, 15);
    chk_eq("edge_rsp_valid",   rsp_valid, 1'b1);
    chk_eq("edge_rsp_timeout", rsp_timeout, 1'b0);
    chk_eq("edge_rsp_error",   rsp_error, 1'b0);
    chk_eq("edge_rsp_rdata",   rsp_rdata, 32'hCAFEF00D);
    consume();
    PREADY = 4'b0000;

    // Slave error on slave 2
    PREADY  = 4'b0100;
    PSLVERR = 4'b0100;
    push_cmd(1'b1, 16'h8008, 32'h01020304, 4'h3);
    tick();
    tick();
    tick();
    chk_eq("se_rsp_valid",   rsp_valid, 1'b1);
    chk_eq("se_rsp_error",   rsp_error, 1'b1);
    chk_eq("se_rsp_timeout", rsp_timeout, 1'b0);
    chk_eq("se_rsp_rdata",   rsp_rdata, 32'h0);
    consume();
    PSLVERR = 4'b0000;

    // Backpressure: five reads queued while the response is not taken
    PREADY = 4'b1111;
    PRDATA[0*32 +: 32] = 32'hA0A0A0A0;
    PRDATA[1*32 +: 32] = 32'hB1B1B1B1;
    PRDATA[2*32 +: 32] = 32'hC2C2C2C2;
    PRDATA[3*32 +: 32] = 32'hD3D3D3D3;
    bp_addr[0] = 16'h0000; bp_exp[0] = 32'hA0A0A0A0;
    bp_addr[1] = 16'h4000; bp_exp[1] = 32'hB1B1B1B1;
    bp_addr[2] = 16'h8000; bp_exp[2] = 32'hC2C2C2C2;
    bp_addr[3] = 16'hC000; bp_exp[3] = 32'hD3D3D3D3;
    bp_addr[4] = 16'h0004; bp_exp[4] = 32'hA0A0A0A0;
    for (int i = 0; i < 5; i++) begin
      chk_eq($sformatf("bp_ready_%0d", i), cmd_ready, 1'b1);
      push_cmd(1'b0, bp_addr[i], 32'h0, 4'h0);
    end
    chk_eq("bp_full_count", cmd_count, 3'd4);
    chk_eq("bp_full_ready", cmd_ready, 1'b0);
    chk_eq("bp_rsp_valid",  rsp_valid, 1'b1);
    cmd_valid = 1'b1;
    cmd_addr  = 16'h4444;
    repeat (5) tick();
    cmd_valid = 1'b0;
    chk_eq("bp_stall_count", cmd_count, 3'd4);
    chk_eq("bp_stall_psel",  PSEL, 4'b0000);
    chk_eq("bp_stall_rdata", rsp_rdata, 32'hA0A0A0A0);
    rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 200) begin
      if (rsp_valid === 1'b1) begin
        chk_eq($sformatf("bp_rdata_%0d", got), rsp_rdata, bp_exp[got]);
        got++;
      end
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    chk_eq("bp_resp_count",  got, 5);
    chk_eq("bp_drain_count", cmd_count, 3'd0);
    chk_eq("bp_drain_ready", cmd_ready, 1'b1);
    chk_eq("bp_drain_rspv",  rsp_valid, 1'b0);

    // Reset in the middle of ACCESS
    PREADY = 4'b0000;
    push_cmd(1'b1, 16'h4020, 32'h0BADF00D, 4'hF);
    push_cmd(1'b1, 16'h8030, 32'h00C0FFEE, 4'hF);
    tick();
    chk_eq("mr_penable", PENABLE, 1'b1);
    chk_eq("mr_count",   cmd_count, 3'd1);
    PRESET = 1'b1;
    tick();
    chk_eq("mr_rst_psel",      PSEL, 4'b0000);
    chk_eq("mr_rst_penable",   PENABLE, 1'b0);
    chk_eq("mr_rst_count",     cmd_count, 3'd0);
    chk_eq("mr_rst_rsp_valid", rsp_valid, 1'b0);
    chk_eq("mr_rst_cmd_ready", cmd_ready, 1'b0);
    chk_eq("mr_rst_paddr",     PADDR, 16'h0000);
    PRESET = 1'b0;
    tick();
    chk_eq("mr_rel_cmd_ready", cmd_ready, 1'b1);
    tick();
    chk_eq("mr_rel_psel", PSEL, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_mq.md
APB_MASTER_MQ -- requirements
Module: apb_master_mq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, slave count; power of 2, >=2; SIDX_W = log2(NUM_SLAVES).
REQ-004 SHALL have parameter CMD_DEPTH, default 4, command FIFO depth; power of 2, >=2.
REQ-005 SHALL have parameter TIMEOUT, default 15, max ACCESS wait cycles; >=1.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 SHALL have port PCLK, in, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port PRESET, in, 1, synchronous active-high reset.
REQ-009 SHALL have port cmd_valid, in, 1, command offered.
REQ-010 SHALL have port cmd_ready, out, 1, FIFO can accept a command.
REQ-011 SHALL have port cmd_write, in, 1, 1=write, 0=read.
REQ-012 SHALL have port cmd_addr, in, ADDR_WIDTH, transfer address.
REQ-013 SHALL have port cmd_wdata, in, DATA_WIDTH, write data.
REQ-014 SHALL have port cmd_strb, in, DATA_WIDTH/8, write strobe.
REQ-015 SHALL have port rsp_valid, out, 1, response held.
REQ-016 SHALL have port rsp_ready, in, 1, response consumed.
REQ-017 SHALL have port rsp_rdata, out, DATA_WIDTH, read data; 0 for writes and timeouts.
REQ-018 SHALL have port rsp_error, out, 1, PSLVERR seen or timeout.
REQ-019 SHALL have port rsp_timeout, out, 1, transfer ended by timeout.
REQ-020 SHALL have port cmd_count, out, log2(CMD_DEPTH)+1, FIFO occupancy.
REQ-021 SHALL have APB ports PADDR (out, ADDR_WIDTH), PSEL (out, NUM_SLAVES, one-hot), PENABLE (out, 1), PWRITE (out, 1), PWDATA (out, DATA_WIDTH) and PSTRB (out, DATA_WIDTH/8).
REQ-022 SHALL have per-slave return ports PRDATA (in, NUM_SLAVES*DATA_WIDTH, slave i at [i*DATA_WIDTH +: DATA_WIDTH]), PREADY (in, NUM_SLAVES) and PSLVERR (in, NUM_SLAVES).

Function
REQ-023 SHALL push a command on every cycle with cmd_valid && cmd_ready; cmd_ready = (cmd_count < CMD_DEPTH), no push when full even if a pop occurs that cycle.
REQ-024 SHALL run FSM IDLE->SETUP->ACCESS->IDLE; IDLE->SETUP when FIFO non-empty and (!rsp_valid || rsp_ready), popping the head entry on that edge.
REQ-025 SHALL drive in SETUP: PADDR=head addr, PSEL one-hot at index cmd_addr[ADDR_WIDTH-1 -: SIDX_W], PENABLE=0, PWRITE, PWDATA/PSTRB = data/strobe for writes and 0 for reads.
REQ-026 SHALL enter ACCESS unconditionally after one SETUP cycle with PENABLE=1 and all other APB outputs held stable.
REQ-027 SHALL sample only the selected slave's PREADY/PSLVERR/PRDATA; unselected slaves' inputs have no effect.
REQ-028 SHALL complete on selected PREADY=1 in ACCESS: load rsp_rdata (PRDATA for reads, else 0), rsp_error=PSLVERR, rsp_timeout=0, set rsp_valid, return to IDLE with PSEL=0, PENABLE=0.
REQ-029 SHALL count ACCESS cycles with PREADY=0; when the count reaches TIMEOUT, complete next edge with rsp_error=1, rsp_timeout=1, rsp_rdata=0, deassert PSEL/PENABLE.
REQ-030 SHALL clear the wait counter on every entry to SETUP; PREADY=1 in the TIMEOUT-th cycle is a normal completion.
REQ-031 SHALL hold rsp_* stable while rsp_valid && !rsp_ready; clear rsp_valid on rsp_valid && rsp_ready unless reloaded that edge.
REQ-032 SHALL, with zero wait states, have a command pushed at edge E0 show SETUP after E1, ACCESS after E2 and rsp_valid after E3.
REQ-033 SHALL hold PADDR/PWRITE/PWDATA/PSTRB at last values in IDLE.

Reset
REQ-034 SHALL on PRESET=1 at a clock edge set all outputs to 0 (cmd_ready=0), empty the FIFO, set state IDLE and clear the wait counter, aborting any in-flight transfer.
REQ-035 SHALL raise cmd_ready to 1 on the first edge with PRESET=0.

Verification
REQ-036 SHALL cover write: cmd write addr 0x4010, data 0xDEADBEEF, strb 0xF; slave 1 PREADY=1 -> PSEL=4'b0010 SETUP then ACCESS, rsp_valid after E3, rsp_error=0.
REQ-037 SHALL cover read with waits: read addr 0xC004; slave 3 PREADY low 3 cycles, PRDATA=0x12345678 -> ACCESS 4 cycles, rsp_rdata=0x12345678.
REQ-038 SHALL cover timeout: TIMEOUT=15, slave PREADY stuck 0 -> 15 ACCESS cycles, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 SHALL cover backpressure: 5 pushes, rsp_ready=0 -> cmd_ready=0 at cmd_count=4; one transfer runs; none starts until rsp_ready=1.
REQ-040 SHALL cover slave error: PSLVERR=1 with PREADY=1 on slave 2 -> rsp_error=1, rsp_timeout=0.
REQ-041 SHALL cover reset mid-ACCESS: PRESET=1 -> next edge PSEL=0, PENABLE=0, cmd_count=0, rsp_valid=0.
